// File: rtl/line_mem.sv
// rtl/line_mem.sv - pipelined line-organised data memory with strobed writes and window checking
module line_mem #(
  parameter logic [31:0] BASE_ADDR      = 32'd20000,
  parameter int unsigned DEPTH          = 1024,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned XLEN           = 32,
  parameter int unsigned RD_LATENCY     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_adr,
  input  logic [XLEN-1:0]   req_data,
  input  logic [XLEN/8-1:0] req_strobe,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_data,
  output logic              resp_error
);

  localparam int unsigned BYTES  = XLEN / 8;
  localparam int unsigned OFF_W  = $clog2(BYTES);
  localparam int unsigned NWORDS = DEPTH * WORDS_PER_LINE;
  localparam int unsigned IDX_W  = $clog2(NWORDS);

  // Window bounds are held at 33 bits so a window ending exactly at 2^32
  // cannot wrap back onto low addresses.
  localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI = WIN_LO + 33'(NWORDS * BYTES);

  // Storage is line-major, so line*WORDS_PER_LINE + cell is simply the
  // low IDX_W bits of the word offset inside the window.
  logic [XLEN-1:0] mem_q [NWORDS];

  // Response pipeline: index 0 is stage 1, index RD_LATENCY-1 drives outputs.
  logic            vld_q  [RD_LATENCY];
  logic [XLEN-1:0] data_q [RD_LATENCY];
  logic            err_q  [RD_LATENCY];

  logic [31:0]      local_addr;
  logic [IDX_W-1:0] word_idx;
  logic             in_window;
  logic             misaligned;
  logic             acc_err;
  logic             advance;
  logic             accept;
  logic [XLEN-1:0]  rd_word;
  logic [XLEN-1:0]  s1_data_d;
  logic             s1_err_d;

  assign local_addr = req_adr - BASE_ADDR;
  assign word_idx   = IDX_W'(local_addr >> OFF_W);
  assign in_window  = ({1'b0, req_adr} >= WIN_LO) && ({1'b0, req_adr} < WIN_HI);
  assign misaligned = |req_adr[OFF_W-1:0];
  assign acc_err    = !in_window || misaligned;

  // The whole pipeline moves only when the output slot is free or being taken.
  assign advance   = !vld_q[RD_LATENCY-1] || resp_ready;
  assign req_ready = advance && !rst;
  assign accept    = req_valid && req_ready;

  // Writes and errored accesses answer with zero data.
  assign rd_word   = mem_q[word_idx];
  assign s1_data_d = (accept && !req_we && !acc_err) ? rd_word : '0;
  assign s1_err_d  = accept && acc_err;

  // Commit the strobed bytes of an accepted, legal write; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && req_we && !acc_err) begin
      for (int b = 0; b < int'(BYTES); b++) begin
        if (req_strobe[b]) begin
          mem_q[word_idx][8*b +: 8] <= req_data[8*b +: 8];
        end
      end
    end
  end

  // Load stage 1 on acceptance and shift every stage when advancing; reset drops in-flight responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(RD_LATENCY); k++) begin
        vld_q[k]  <= 1'b0;
        data_q[k] <= '0;
        err_q[k]  <= 1'b0;
      end
    end else if (advance) begin
      vld_q[0]  <= accept;
      data_q[0] <= s1_data_d;
      err_q[0]  <= s1_err_d;
      for (int k = 1; k < int'(RD_LATENCY); k++) begin
        vld_q[k]  <= vld_q[k-1];
        data_q[k] <= data_q[k-1];
        err_q[k]  <= err_q[k-1];
      end
    end
  end

  assign resp_valid = vld_q[RD_LATENCY-1];
  assign resp_data  = data_q[RD_LATENCY-1];
  assign resp_error = err_q[RD_LATENCY-1];

endmodule
